// File: rtl/timelock_pkg.sv
// Shared constants and helpers for the timelock arbiter controller and its
// round-robin grant logic.
package timelock_pkg;

  localparam int unsigned TL_W_DEFAULT       = 184;
  localparam logic [32:0] TL_TIMEOUT_DEFAULT = 33'd16777216;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // A lone valid requester wins; with both valid the pointer decides.
  function automatic logic tl_rr_pick(input logic [1:0] valid, input logic ptr);
    logic pick;
    case (valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ptr;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/timelock_arbiter_rr.sv
// Two-way round-robin grant: one-hot grant plus index from valid and pointer.
module rr_arbiter2
  import timelock_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       any_valid
);

  assign gnt_idx   = tl_rr_pick(valid, ptr);
  assign any_valid = |valid;
  assign gnt       = any_valid ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/timelock_arbiter.sv
// Shares one iterative core between two requesters, with round-robin grant
// and a cycle-count abort that returns a zero result flagged as an error.
module timelock_arbiter
  import timelock_pkg::*;
#(
  parameter int unsigned W       = TL_W_DEFAULT,
  parameter logic [32:0] TIMEOUT = TL_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_xs,
  input  logic [W-1:0] req0_xc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_xs,
  input  logic [W-1:0] req1_xc,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [W-1:0] resp0_ys,
  output logic [W-1:0] resp0_yc,
  output logic         resp0_err,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [W-1:0] resp1_ys,
  output logic [W-1:0] resp1_yc,
  output logic         resp1_err,
  output logic         core_ld,
  output logic [W-1:0] core_xs,
  output logic [W-1:0] core_xc,
  input  logic         core_dn,
  input  logic [W-1:0] core_ys,
  input  logic [W-1:0] core_yc,
  output logic         busy
);

  // A TIMEOUT of 2**32 truncates to zero here, so the last count becomes all-ones.
  localparam logic [31:0] CNT_LAST_C = TIMEOUT[31:0] - 32'd1;

  logic [1:0]   state_r, state_s;
  logic [1:0]   req_valid_s, gnt_s;
  logic         gnt_idx_s, any_s, take_s, nxt_gnt_s;
  logic         run_done_s, run_tmo_s, resp_ack_s;
  logic         gnt_idx_r, ptr_r, err_r;
  logic [31:0]  cnt_r;
  logic [W-1:0] op_xs_r, op_xc_r, res_ys_r, res_yc_r;
  logic         core_ld_r, busy_r, resp0_valid_r, resp1_valid_r;

  assign req_valid_s = {req1_valid, req0_valid};

  rr_arbiter2 u_rr_arbiter2 (
    .valid     (req_valid_s),
    .ptr       (ptr_r),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .any_valid (any_s)
  );

  assign take_s     = (state_r == ST_IDLE) && any_s;
  assign run_done_s = (state_r == ST_RUN) && core_dn;
  assign run_tmo_s  = (state_r == ST_RUN) && !core_dn && (cnt_r == CNT_LAST_C);
  assign resp_ack_s = (state_r == ST_RESP) && (gnt_idx_r ? resp1_ready : resp0_ready);

  // Ready is the grant itself, so it is masked while reset holds the FSM.
  assign req0_ready = take_s && gnt_s[0] && !rst;
  assign req1_ready = take_s && gnt_s[1] && !rst;

  assign core_ld     = core_ld_r;
  assign busy        = busy_r;
  assign core_xs     = op_xs_r;
  assign core_xc     = op_xc_r;
  assign resp0_valid = resp0_valid_r;
  assign resp1_valid = resp1_valid_r;
  assign resp0_ys    = res_ys_r;
  assign resp0_yc    = res_yc_r;
  assign resp1_ys    = res_ys_r;
  assign resp1_yc    = res_yc_r;
  assign resp0_err   = err_r;
  assign resp1_err   = err_r;

  // Next-state decode for the job sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (any_s) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD: state_s = ST_RUN;
      ST_RUN:  if (run_done_s || run_tmo_s) state_s = ST_RESP; else state_s = ST_RUN;
      ST_RESP: if (resp_ack_s) state_s = ST_IDLE; else state_s = ST_RESP;
      default: state_s = ST_IDLE;
    endcase
  end

  // Grant index that will own the job in the next cycle.
  always_comb begin
    nxt_gnt_s = gnt_idx_r;
    if (take_s) nxt_gnt_s = gnt_idx_s;
    else        nxt_gnt_s = gnt_idx_r;
  end

  // State register and state-decoded outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      core_ld_r     <= 1'b1;
      busy_r        <= 1'b0;
      resp0_valid_r <= 1'b0;
      resp1_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      core_ld_r     <= (state_s != ST_RUN);
      busy_r        <= (state_s != ST_IDLE);
      resp0_valid_r <= (state_s == ST_RESP) && !nxt_gnt_s;
      resp1_valid_r <= (state_s == ST_RESP) && nxt_gnt_s;
    end
  end

  // Grant capture, operand latch and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx_r <= 1'b0;
      ptr_r     <= 1'b0;
      op_xs_r   <= '0;
      op_xc_r   <= '0;
    end else begin
      if (take_s) begin
        gnt_idx_r <= gnt_idx_s;
        op_xs_r   <= gnt_idx_s ? req1_xs : req0_xs;
        op_xc_r   <= gnt_idx_s ? req1_xc : req0_xc;
      end
      if (resp_ack_s) ptr_r <= !gnt_idx_r;
    end
  end

  // Compute-cycle counter: zero on the first RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (state_r == ST_LOAD) begin
      cnt_r <= 32'd0;
    end else if (state_r == ST_RUN) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  // Result capture; a done in the timeout cycle still wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_ys_r <= '0;
      res_yc_r <= '0;
      err_r    <= 1'b0;
    end else if (run_done_s) begin
      res_ys_r <= core_ys;
      res_yc_r <= core_yc;
      err_r    <= 1'b0;
    end else if (run_tmo_s) begin
      res_ys_r <= '0;
      res_yc_r <= '0;
      err_r    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timelock_arbiter.sv
// Table-driven bench for timelock_arbiter with a scripted core model and a
// response scoreboard.
module tb_timelock_arbiter;

  typedef struct {
    logic       v0, v1;
    logic [7:0] xs0, xc0, xs1, xc1;
    int         dn_cnt;
    logic       dn_ld;
    logic [7:0] ys, yc;
    logic       gi;
    int         hold;
  } vec_t;

  typedef struct {
    logic       idx;
    logic [7:0] ys, yc;
    logic       err;
    int         run_len;
  } sb_t;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_xs, req0_xc, req1_xs, req1_xc;
  logic       resp0_valid, resp0_ready, resp0_err, resp1_valid, resp1_ready, resp1_err;
  logic [7:0] resp0_ys, resp0_yc, resp1_ys, resp1_yc;
  logic       core_ld, core_dn, busy;
  logic [7:0] core_xs, core_xc, core_ys, core_yc;

  logic dn_model, dn_force, dn_in_ld;
  int   dn_cnt, run_cnt;
  int   n_cmp, n_bad;
  sb_t  sb_q[$];
  vec_t vecs[9];
  vec_t post_v;

  assign core_dn = dn_model | dn_force;

  timelock_arbiter #(.W(8), .TIMEOUT(33'd16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_xs(req0_xs), .req0_xc(req0_xc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_xs(req1_xs), .req1_xc(req1_xc),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_ys(resp0_ys),
    .resp0_yc(resp0_yc), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_ys(resp1_ys),
    .resp1_yc(resp1_yc), .resp1_err(resp1_err),
    .core_ld(core_ld), .core_xs(core_xs), .core_xc(core_xc), .core_dn(core_dn),
    .core_ys(core_ys), .core_yc(core_yc), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual no_finish required finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic string tag(input int id, input string s);
    return $sformatf("v%0d_%s", id, s);
  endfunction

  // Core model: counts RUN cycles and raises done when the DUT counter equals dn_cnt.
  initial begin
    run_cnt  = 0;
    dn_model = 1'b0;
    forever begin
      @(negedge clk);
      if (!core_ld) run_cnt = run_cnt + 1;
      else if (!busy) run_cnt = 0;
      dn_model = (!core_ld && dn_cnt >= 0 && run_cnt == dn_cnt + 1) || (core_ld && busy && dn_in_ld);
    end
  end

  // Scoreboard: compare every accepted response against the oldest expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready))) begin
        if (sb_q.size() == 0) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL resp_unexpected: actual valid=%b%b required none", resp1_valid, resp0_valid);
        end else begin
          e = sb_q.pop_front();
          check("resp_route", 32'({resp1_valid, resp0_valid}), e.idx ? 32'd2 : 32'd1);
          check("resp_ys", 32'(e.idx ? resp1_ys : resp0_ys), 32'(e.ys));
          check("resp_yc", 32'(e.idx ? resp1_yc : resp0_yc), 32'(e.yc));
          check("resp_err", 32'(e.idx ? resp1_err : resp0_err), 32'(e.err));
          check("resp_run_len", 32'(run_cnt), 32'(e.run_len));
        end
      end
    end
  end

  task automatic run_job(input int id, input vec_t v);
    int n;
    sb_t e;
    logic [7:0] exs, exc;
    dn_cnt = v.dn_cnt;
    dn_in_ld = v.dn_ld;
    core_ys = v.ys;
    core_yc = v.yc;
    req0_valid = v.v0; req0_xs = v.xs0; req0_xc = v.xc0;
    req1_valid = v.v1; req1_xs = v.xs1; req1_xc = v.xc1;
    resp0_ready = (v.hold == 0);
    resp1_ready = (v.hold == 0);
    exs = v.gi ? v.xs1 : v.xs0;
    exc = v.gi ? v.xc1 : v.xc0;
    n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 40) begin
      @(negedge clk); #1; n = n + 1;
    end
    check(tag(id, "grant_seen"), 32'(n < 40), 32'd1);
    check(tag(id, "grant_idx"), 32'({req1_ready, req0_ready}), v.gi ? 32'd2 : 32'd1);
    e.idx = v.gi;
    e.err = (v.dn_cnt < 0);
    e.ys = e.err ? 8'h00 : v.ys;
    e.yc = e.err ? 8'h00 : v.yc;
    e.run_len = e.err ? 16 : v.dn_cnt + 1;
    sb_q.push_back(e);
    @(negedge clk); #1;
    check(tag(id, "ready_pulse"), 32'({req1_ready, req0_ready}), 32'd0);
    check(tag(id, "load_ld_busy"), 32'({core_ld, busy}), 32'd3);
    check(tag(id, "load_xs"), 32'(core_xs), 32'(exs));
    check(tag(id, "load_xc"), 32'(core_xc), 32'(exc));
    if (v.gi) begin
      req1_valid = 1'b0; req1_xs = ~v.xs1; req1_xc = ~v.xc1;
    end else begin
      req0_valid = 1'b0; req0_xs = ~v.xs0; req0_xc = ~v.xc0;
    end
    @(negedge clk); #1;
    check(tag(id, "run_ld"), 32'(core_ld), 32'd0);
    check(tag(id, "run_xs"), 32'({core_xs, core_xc}), 32'({exs, exc}));
    n = 0;
    while (!(v.gi ? resp1_valid : resp0_valid) && n < 40) begin
      @(negedge clk); #1; n = n + 1;
    end
    check(tag(id, "resp_seen"), 32'(n < 40), 32'd1);
    repeat (v.hold) begin
      @(negedge clk); #1;
      check(tag(id, "resp_held"), 32'({resp1_valid, resp0_valid}), v.gi ? 32'd2 : 32'd1);
    end
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    @(negedge clk); #1;
    check(tag(id, "idle_after"), 32'({resp1_valid, resp0_valid, busy}), 32'd0);
    check(tag(id, "sb_drained"), 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_xs = 8'h00; req0_xc = 8'h00; req1_xs = 8'h00; req1_xc = 8'h00;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    core_ys = 8'h00; core_yc = 8'h00;
    dn_force = 1'b0; dn_in_ld = 1'b0; dn_cnt = -1;

    //          v0    v1    xs0    xc0    xs1    xc1   dn  dn_ld  ys     yc     gi   hold
    vecs[0] = '{1'b1, 1'b1, 8'h12, 8'h34, 8'h9A, 8'hBC, 5, 1'b0, 8'h56, 8'h78, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 8'h12, 8'h34, 8'h9A, 8'hBC, 2, 1'b0, 8'hA1, 8'hB2, 1'b1, 0};
    vecs[2] = '{1'b1, 1'b1, 8'h21, 8'h43, 8'h9A, 8'hBC, 0, 1'b0, 8'hC3, 8'hD4, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 8'h0F, 8'hF0, 8'h00, 8'h00, 7, 1'b0, 8'h11, 8'h22, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h5A, 3, 1'b0, 8'h33, 8'h44, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, -1, 1'b0, 8'h5F, 8'h6F, 1'b1, 0};
    vecs[6] = '{1'b1, 1'b0, 8'h01, 8'h80, 8'h00, 8'h00, 15, 1'b0, 8'h5A, 8'hA5, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b0, 8'h3C, 8'hC3, 8'h00, 8'h00, 5, 1'b1, 8'h66, 8'h77, 1'b0, 0};
    vecs[8] = '{1'b1, 1'b0, 8'h77, 8'h88, 8'h00, 8'h00, 1, 1'b0, 8'h7E, 8'h7F, 1'b0, 3};
    post_v  = '{1'b1, 1'b1, 8'hB1, 8'hB2, 8'hC1, 8'hC2, 4, 1'b0, 8'h21, 8'h43, 1'b0, 0};

    repeat (2) @(negedge clk);
    #1;
    check("rst_ld_busy", 32'({core_ld, busy}), 32'd2);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
    check("rst_regs", 32'({core_xs, core_xc, resp0_ys, resp0_yc}), 32'd0);
    check("rst_err", 32'({resp1_err, resp0_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 9; i++) run_job(i, vecs[i]);

    // Abandon a job mid-RUN with reset; a stray done must not produce a response.
    dn_cnt = -1;
    dn_in_ld = 1'b0;
    req0_valid = 1'b1; req0_xs = 8'hE1; req0_xc = 8'hE2;
    #1;
    check("rstseq_grant", 32'(req0_ready), 32'd1);
    @(negedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rstseq_in_run", 32'({busy, core_ld}), 32'd2);
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("rstseq_ld_busy", 32'({core_ld, busy}), 32'd2);
    check("rstseq_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
    check("rstseq_ready", 32'(req1_ready), 32'd0);
    check("rstseq_regs", 32'({core_xs, core_xc, resp0_ys, resp0_yc}), 32'd0);
    @(negedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b0;
    dn_force = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("rstseq_quiet", 32'({busy, resp1_valid, resp0_valid}), 32'd0);
    end
    dn_force = 1'b0;
    run_job(9, post_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
